ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 141 ++++++++++++++
 tb/tb_ifu.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM with a one-entry output buffer.
// Optional feature macro: IFU_HALT_ON_EBREAK_EN (stop fetching after an ebreak is consumed).
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        halted
);

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              drop, drop_n;
  logic [DATA_W-1:0] inst_n;
  logic [ADDR_W-1:0] inst_pc_n;
  logic              req_fire_c;
  logic              consume_c;
  logic              is_ebreak_c;
  logic [ADDR_W-1:0] redirect_tgt_c;

  assign imem_req_addr  = pc;
  assign req_fire_c     = imem_req_valid & imem_req_ready;
  assign consume_c      = inst_valid & inst_ready;
  assign redirect_tgt_c = redirect_pc & ~ADDR_W'(3);
`ifdef IFU_HALT_ON_EBREAK_EN
  assign is_ebreak_c    = (inst == EBREAK);
`else
  assign is_ebreak_c    = 1'b0;
`endif

  // Next-state, next-pc and buffer capture; redirect wins over every other event
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    drop_n    = drop;
    inst_n    = inst;
    inst_pc_n = inst_pc;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_n = redirect_tgt_c;
          if (req_fire_c) begin
            state_n = S_WAIT;
            drop_n  = 1'b1;
          end
        end else if (req_fire_c) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_tgt_c;
          if (imem_rsp_valid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            inst_n    = imem_rsp_data;
            inst_pc_n = pc;
            state_n   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_tgt_c;
          state_n = S_REQ;
        end else if (consume_c) begin
          pc_n    = pc + ADDR_W'(4);
          state_n = is_ebreak_c ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_REQ;
      end
    endcase
  end

  // State, pc and registered outputs with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      drop           <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      drop           <= drop_n;
      inst           <= inst_n;
      inst_pc        <= inst_pc_n;
      imem_req_valid <= (state_n == S_REQ);
      inst_valid     <= (state_n == S_HOLD);
    end
  end

`ifdef IFU_HALT_ON_EBREAK_EN
  // Sticky halt flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (!reset_n) halted <= 1'b0;
    else          halted <= (state_n == S_HALT);
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu; follows IFU_HALT_ON_EBREAK_EN if defined.
module tb_ifu;

  logic        clock;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  ifu #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then let outputs settle before sampling
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From REQ with valid shown: check request, accept it, return data next cycle, check buffer
  task automatic fetch(input logic [31:0] data, input logic [63:0] pc);
    chk("req_valid", 64'(imem_req_valid), 64'd1);
    chk("req_addr", imem_req_addr, pc);
    tick();
    chk("wait_req_valid", 64'(imem_req_valid), 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    chk("hold_inst_valid", 64'(inst_valid), 64'd1);
    chk("hold_inst", 64'(inst), 64'(data));
    chk("hold_inst_pc", inst_pc, pc);
  endtask

  initial begin
    reset_n        = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    tick();
    tick();
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);

    // Streaming fetch with always-ready memory and consumer
    reset_n = 1'b1;
    tick();
    fetch(32'h1111_1111, 64'h8000_0000);
    tick();
    chk("c1_inst_valid", 64'(inst_valid), 64'd0);
    fetch(32'h2222_2222, 64'h8000_0004);
    tick();
    fetch(32'h3333_3333, 64'h8000_0008);

    // Backpressure in HOLD: buffer stable, no new request
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_inst_valid", 64'(inst_valid), 64'd1);
      chk("bp_inst", 64'(inst), 64'h3333_3333);
      chk("bp_inst_pc", inst_pc, 64'h8000_0008);
      chk("bp_req_valid", 64'(imem_req_valid), 64'd0);
    end
    inst_ready = 1'b1;
    tick();
    chk("bp_next_req_valid", 64'(imem_req_valid), 64'd1);
    chk("bp_next_addr", imem_req_addr, 64'h8000_000C);

    // Redirect in WAIT with response in the same cycle: response dropped
    tick();
    chk("rw_wait", 64'(imem_req_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1003;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("rw_inst_valid", 64'(inst_valid), 64'd0);
    fetch(32'h4444_4444, 64'h8000_1000);

    // Redirect in HOLD with inst_ready=1: buffer invalidated, not consumed
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("rh_inst_valid", 64'(inst_valid), 64'd0);
    fetch(32'h5555_5555, 64'hFFFF_FFFF_FFFF_FFFC);

    // pc+4 wraps to zero
    tick();
    chk("wrap_req_valid", 64'(imem_req_valid), 64'd1);
    chk("wrap_addr", imem_req_addr, 64'd0);

    // Redirect in REQ with handshake: next response dropped
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick();
    redirect_valid = 1'b0;
    chk("rr_wait", 64'(imem_req_valid), 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    imem_rsp_valid = 1'b0;
    chk("rr_inst_valid", 64'(inst_valid), 64'd0);
    chk("rr_req_valid", 64'(imem_req_valid), 64'd1);
    chk("rr_addr", imem_req_addr, 64'h200);

    // Redirect in REQ without handshake: address moves, still requesting
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h301;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    fetch(32'h0010_0073, 64'h300);

    // Consume ebreak
    tick();
`ifdef IFU_HALT_ON_EBREAK_EN
    chk("eb_halted", 64'(halted), 64'd1);
    chk("eb_req_valid", 64'(imem_req_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h400;
    tick();
    tick();
    redirect_valid = 1'b0;
    chk("eb_redir_req_valid", 64'(imem_req_valid), 64'd0);
    chk("eb_redir_inst_valid", 64'(inst_valid), 64'd0);
    chk("eb_redir_halted", 64'(halted), 64'd1);
`else
    chk("eb_halted", 64'(halted), 64'd0);
    chk("eb_req_valid", 64'(imem_req_valid), 64'd1);
    chk("eb_addr", imem_req_addr, 64'h304);
`endif

    // Reset then one-cycle reset while HOLD
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rr2_halted", 64'(halted), 64'd0);
    tick();
    fetch(32'h6666_6666, 64'h8000_0000);
    reset_n    = 1'b0;
    inst_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rh_rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rh_rst_inst", 64'(inst), 64'd0);
    chk("rh_rst_req_valid", 64'(imem_req_valid), 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h7777_7777;
    tick();
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b1;
    chk("rh_stale_inst_valid", 64'(inst_valid), 64'd0);
    fetch(32'h8888_8888, 64'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
